// File: rtl/pipe_slice_pkg.sv
// Shared helpers for the pipe_slice register chain: occupancy counter
// sizing and the encoding of per-cycle occupancy updates.
package pipe_slice_pkg;

  // Ceiling log2 for elaboration-time sizing (valid for value >= 1).
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    while ((32'sd1 <<< result) < value) begin
      result = result + 32'sd1;
    end
    return result;
  endfunction

  // Occupancy must hold 0..STAGES+1 (all stages plus the skid entry).
  function automatic int occ_width(input int stages);
    return clog2(stages + 32'sd2);
  endfunction

  // {input handshake, output handshake} for one cycle.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_DEC  = 2'b01,
    OCC_INC  = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_e;

endpackage

// File: rtl/pipe_skid.sv
// One-entry skid buffer placed in front of stage 0. in_ready comes straight
// from a flop, which breaks the combinational ready path from downstream.
// A word accepted while stage 0 is blocked is parked here and is always
// offered to stage 0 before any fresh input, so ordering is preserved.
module pipe_skid #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             skid_v_r;
  logic [WIDTH-1:0] skid_d_r;

  // Park an accepted word that stage 0 cannot take; release it when stage 0 frees up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_v_r <= 1'b0;
      skid_d_r <= {WIDTH{1'b0}};
    end else if (flush) begin
      skid_v_r <= 1'b0;
    end else if (skid_v_r) begin
      if (out_ready) begin
        skid_v_r <= 1'b0;
      end
    end else if (in_valid && !out_ready) begin
      skid_v_r <= 1'b1;
      skid_d_r <= in_data;
    end
  end

  // Present the parked word first; otherwise pass the input straight through.
  always_comb begin
    in_ready = !skid_v_r;
    if (skid_v_r) begin
      out_valid = 1'b1;
      out_data  = skid_d_r;
    end else begin
      out_valid = in_valid;
      out_data  = in_data;
    end
  end

endmodule

// File: rtl/pipe_slice.sv
// Parametrised valid/ready register chain with bubble collapsing, synchronous
// flush and an optional skid buffer in front of the first stage.
// Stage 0 is on the input side, stage STAGES-1 drives the outputs.
module pipe_slice
  import pipe_slice_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1,
  parameter int SKID   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [occ_width(STAGES)-1:0]   occupancy
);

  localparam int OCC_W = occ_width(STAGES);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1'b1);

  logic [STAGES-1:0] v_vec;
  logic [WIDTH-1:0]  data_arr [STAGES];
  logic [STAGES-1:0] rdy;
  logic              src_valid;
  logic [WIDTH-1:0]  src_data;
  logic              in_acc;
  logic              out_acc;
  logic [OCC_W-1:0]  occ_r;

  // Ready ripples from the output back to stage 0; an empty stage is always ready.
  always_comb begin : rdy_calc
    logic chain;
    chain = out_ready;
    rdy   = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain  = !v_vec[i] || chain;
      rdy[i] = chain;
    end
  end

  if (SKID != 0) begin : g_skid
    pipe_skid #(
      .WIDTH(WIDTH)
    ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(src_valid),
      .out_ready(rdy[0]),
      .out_data (src_data)
    );
  end else begin : g_direct
    assign in_ready  = rdy[0];
    assign src_valid = in_valid;
    assign src_data  = in_data;
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             prev_v;
    logic [WIDTH-1:0] prev_d;
    logic             v_r;
    logic [WIDTH-1:0] d_r;

    if (i == 0) begin : g_first
      assign prev_v = src_valid;
      assign prev_d = src_data;
    end else begin : g_next
      assign prev_v = v_vec[i-1];
      assign prev_d = data_arr[i-1];
    end

    // Take the upstream word whenever this stage is ready; flush clears valid but keeps data.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_r <= 1'b0;
        d_r <= {WIDTH{1'b0}};
      end else if (flush) begin
        v_r <= 1'b0;
      end else if (rdy[i]) begin
        v_r <= prev_v;
        if (prev_v) begin
          d_r <= prev_d;
        end
      end
    end

    assign v_vec[i]    = v_r;
    assign data_arr[i] = d_r;
  end

  assign out_valid = v_vec[STAGES-1];
  assign out_data  = data_arr[STAGES-1];
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign occupancy = occ_r;

  // Track words held (stages plus skid) from the two handshakes; flush empties everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (flush) begin
      occ_r <= {OCC_W{1'b0}};
    end else begin
      case (occ_op_e'({in_acc, out_acc}))
        OCC_INC: occ_r <= occ_r + OCC_ONE;
        OCC_DEC: occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_slice.sv
// Bench for pipe_slice: two instances (3 stages without skid, 2 stages with
// skid) driven by directed phases and then random traffic. A reference model
// keeps the words held by each instance as a queue, derives ready/valid and
// occupancy from queue size, and times each word's arrival at the output as
// max(accept edge + STAGES - 1, departure edge of the word ahead). A separate
// monitor pops a scoreboard on every output handshake and checks the data.
module tb_pipe_slice;

  localparam int W  = 32;
  localparam int SA = 3;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv   [2];
  logic         ordy [2];
  logic         fl   [2];
  logic [W-1:0] id   [2];
  logic         ir   [2];
  logic         ov   [2];
  logic [W-1:0] od   [2];
  logic [2:0]   occ_a;
  logic [1:0]   occ_b;

  pipe_slice #(.WIDTH(W), .STAGES(SA), .SKID(0)) dut_a (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(id[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
    .occupancy(occ_a)
  );

  pipe_slice #(.WIDTH(W), .STAGES(SB), .SKID(1)) dut_b (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(id[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
    .occupancy(occ_b)
  );

  // Next-cycle stimulus, applied on the falling edge by step().
  logic         nxt_rst;
  logic         nxt_iv   [2];
  logic         nxt_ordy [2];
  logic         nxt_fl   [2];
  logic [W-1:0] nxt_id   [2];

  // Reference model state.
  int           stages   [2] = '{SA, SB};
  int           has_skid [2] = '{0, 1};
  logic [W-1:0] mq       [2][$];
  int           macc     [2][$];
  int           head_arr [2] = '{0, 0};
  int           last_dep [2] = '{0, 0};
  logic [W-1:0] sb       [2][$];

  int vectors     = 0;
  int miscompares = 0;
  int edge_cnt    = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input int d, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d at edge %0d: got %h expected %h", name, d, edge_cnt, act, exp);
    end
  endtask

  task automatic check_and_update(input int d);
    int   n;
    int   cnt;
    int   occ_act;
    int   nat;
    bit   e_ov;
    bit   e_ir;
    bit   in_acc;
    bit   out_acc;
    n       = edge_cnt;
    occ_act = (d == 0) ? int'(occ_a) : int'(occ_b);
    if (!rst) begin
      mq[d].delete();
      macc[d].delete();
      sb[d].delete();
      chk("rst_out_valid", d, W'(ov[d]), W'(1'b0));
      chk("rst_occupancy", d, W'(occ_act), W'(0));
      chk("rst_in_ready", d, W'(ir[d]), W'(1'b1));
      chk("rst_out_data", d, od[d], W'(0));
    end else begin
      cnt  = mq[d].size();
      e_ov = (cnt > 0) && (head_arr[d] <= n);
      if (has_skid[d] != 0) e_ir = (cnt <= stages[d]);
      else                  e_ir = (cnt < stages[d]) || ordy[d];
      chk("out_valid", d, W'(ov[d]), W'(e_ov));
      chk("in_ready", d, W'(ir[d]), W'(e_ir));
      chk("occupancy", d, W'(occ_act), W'(cnt));
      if (e_ov) chk("out_data", d, od[d], mq[d][0]);
      in_acc  = iv[d] && e_ir;
      out_acc = e_ov && ordy[d];
      if (out_acc) begin
        void'(mq[d].pop_front());
        void'(macc[d].pop_front());
        last_dep[d] = n + 1;
        if (mq[d].size() > 0) begin
          nat         = macc[d][0] + stages[d] - 1;
          head_arr[d] = (nat > last_dep[d]) ? nat : last_dep[d];
        end
      end
      if (fl[d]) begin
        mq[d].delete();
        macc[d].delete();
        if (out_acc) begin
          while (sb[d].size() > 1) void'(sb[d].pop_back());
        end else begin
          sb[d].delete();
        end
      end else if (in_acc) begin
        if (mq[d].size() == 0) begin
          nat         = n + stages[d];
          head_arr[d] = (nat > last_dep[d]) ? nat : last_dep[d];
        end
        mq[d].push_back(id[d]);
        macc[d].push_back(n + 1);
        sb[d].push_back(id[d]);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst = nxt_rst;
    for (int d = 0; d < 2; d++) begin
      iv[d]   = nxt_iv[d];
      id[d]   = nxt_id[d];
      ordy[d] = nxt_ordy[d];
      fl[d]   = nxt_fl[d];
    end
    #1;
    for (int d = 0; d < 2; d++) check_and_update(d);
  endtask

  task automatic set_all(input logic v, input logic [W-1:0] data, input logic r, input logic f);
    for (int d = 0; d < 2; d++) begin
      nxt_iv[d]   = v;
      nxt_id[d]   = data;
      nxt_ordy[d] = r;
      nxt_fl[d]   = f;
    end
  endtask

  task automatic random_cycles(input int cycles, input int ready_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int d = 0; d < 2; d++) begin
        nxt_iv[d]   = ($urandom_range(3, 0) != 32'd0);
        nxt_id[d]   = $urandom;
        nxt_ordy[d] = ($urandom_range(99, 0) < ready_pct);
        nxt_fl[d]   = ($urandom_range(39, 0) == 32'd0);
      end
      step();
    end
  endtask

  // Scoreboard monitor: every output handshake must deliver the oldest outstanding word.
  initial begin : monitor
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      #3;
      for (int d = 0; d < 2; d++) begin
        if (rst && ov[d] && ordy[d]) begin
          if (sb[d].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL mon_unexpected dut%0d: got %h expected no output", d, od[d]);
          end else begin
            exp_w = sb[d].pop_front();
            chk("mon_data", d, od[d], exp_w);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst     = 1'b0;
    nxt_rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b1; id[d] = 32'h0000_00EE; ordy[d] = 1'b1; fl[d] = 1'b0;
    end
    // Reset held three cycles with input offered.
    set_all(1'b1, 32'h0000_00EE, 1'b1, 1'b0);
    repeat (3) step();
    nxt_rst = 1'b1;
    set_all(1'b0, 32'h0, 1'b1, 1'b0);
    step();
    // Streaming 1,2,3,... at full rate.
    for (int k = 1; k <= 8; k++) begin
      set_all(1'b1, W'(k), 1'b1, 1'b0);
      step();
    end
    set_all(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (5) step();
    // Back-pressure: fill, offer a refused word, then release.
    set_all(1'b1, 32'hA, 1'b0, 1'b0); step();
    set_all(1'b1, 32'hB, 1'b0, 1'b0); step();
    set_all(1'b1, 32'hC, 1'b0, 1'b0); step();
    set_all(1'b1, 32'hD, 1'b0, 1'b0); repeat (2) step();
    set_all(1'b0, 32'h0, 1'b1, 1'b0); repeat (6) step();
    // Bubble collapse behind a stalled output word.
    set_all(1'b1, 32'h4, 1'b0, 1'b0); step();
    set_all(1'b0, 32'h0, 1'b0, 1'b0); repeat (3) step();
    set_all(1'b1, 32'h5, 1'b0, 1'b0); step();
    set_all(1'b0, 32'h0, 1'b0, 1'b0); repeat (2) step();
    set_all(1'b0, 32'h0, 1'b1, 1'b0); repeat (5) step();
    // Flush together with a push and an output handshake.
    for (int k = 0; k < 4; k++) begin
      set_all(1'b1, W'(32'h11 + k), 1'b1, 1'b0);
      step();
    end
    set_all(1'b1, 32'h9, 1'b1, 1'b1); step();
    set_all(1'b0, 32'h0, 1'b1, 1'b0); repeat (4) step();
    // Random traffic, light and heavy back-pressure.
    random_cycles(400, 70);
    random_cycles(300, 25);
    // Reset in the middle of traffic.
    nxt_rst = 1'b0;
    random_cycles(2, 50);
    nxt_rst = 1'b1;
    random_cycles(300, 50);
    // Drain.
    set_all(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (12) step();
    @(negedge clk);
    #4;
    for (int d = 0; d < 2; d++) begin
      chk("drain_scoreboard", d, W'(sb[d].size()), W'(0));
      chk("drain_model", d, W'(mq[d].size()), W'(0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
